// File: rtl/mux4_scan_arbiter.sv
// Round-robin arbiter + sampler in front of a 4:1 mux: picks a requesting channel, holds s0/s1, samples mux_out.
// Latency: select registered one cycle after req is seen; sample valid SETTLE cycles after select.
// Backpressure: sampled data/chan/valid held until valid && ready; select lines never move while held.
module mux4_scan_arbiter #(
    parameter int SETTLE = 1    // select hold before sampling, 1..15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       mux_out,
    input  logic       ready,
    output logic       s0,
    output logic       s1,
    output logic [3:0] grant,
    output logic       data,
    output logic [1:0] chan,
    output logic       valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [1:0]  ptr, ptr_nx;
    logic [1:0]  sel, sel_nx;
    logic [3:0]  grant_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        data_nx;
    logic [1:0]  chan_nx;
    logic        valid_nx;

    logic [1:0]  base;
    logic [1:0]  cand;
    logic [1:0]  pick_idx;
    logic        pick_vld;

    // Round-robin search: first set request bit starting at base, wrapping mod 4.
    // After a handshake the search starts just past the channel that was served.
    always_comb begin
        base     = (state == HOLD) ? chan + 2'd1 : ptr;
        pick_vld = |req;
        pick_idx = base;
        cand     = base;
        for (int i = 3; i >= 0; i--) begin
            cand = base + 2'(i);
            if (req[cand]) pick_idx = cand;
        end
    end

    // Next-state and next-output logic; everything defaults to holding its value.
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        sel_nx   = sel;
        grant_nx = grant;
        cnt_nx   = cnt;
        data_nx  = data;
        chan_nx  = chan;
        valid_nx = valid;
        case (state)
            IDLE: begin
                grant_nx = 4'b0000;
                if (pick_vld) begin
                    sel_nx   = pick_idx;
                    grant_nx = 4'b0001 << pick_idx;
                    cnt_nx   = 4'(SETTLE - 1);
                    state_nx = SEL;
                end
            end
            SEL: begin
                // Request changes are ignored here: a granted channel always completes its sample.
                if (cnt != 4'd0) begin
                    cnt_nx = cnt - 4'd1;
                end else begin
                    data_nx  = mux_out;
                    chan_nx  = sel;
                    valid_nx = 1'b1;
                    grant_nx = 4'b0000;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (valid && ready) begin
                    valid_nx = 1'b0;
                    ptr_nx   = chan + 2'd1;
                    if (pick_vld) begin
                        // Back-to-back arbitration on the handshake edge, no idle bubble.
                        sel_nx   = pick_idx;
                        grant_nx = 4'b0001 << pick_idx;
                        cnt_nx   = 4'(SETTLE - 1);
                        state_nx = SEL;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= 2'd0;
            sel   <= 2'd0;
            grant <= 4'b0000;
            cnt   <= 4'd0;
            data  <= 1'b0;
            chan  <= 2'd0;
            valid <= 1'b0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            sel   <= sel_nx;
            grant <= grant_nx;
            cnt   <= cnt_nx;
            data  <= data_nx;
            chan  <= chan_nx;
            valid <= valid_nx;
        end
    end

    assign s0 = sel[1];
    assign s1 = sel[0];

endmodule

// File: tb/tb_mux4_scan_arbiter.sv
// Directed bench for mux4_scan_arbiter: three instances (SETTLE = 1, 2, 4) share stimulus,
// each scenario observes one instance. Outputs are sampled 1 time unit after the rising edge.
// Each instance drives its own 4:1 mux model built from mux_in.
module tb_mux4_scan_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] mux_in;
    logic       ready;

    logic       s0_1, s1_1, data_1, valid_1;
    logic [3:0] grant_1;
    logic [1:0] chan_1;
    logic       s0_2, s1_2, data_2, valid_2;
    logic [3:0] grant_2;
    logic [1:0] chan_2;
    logic       s0_4, s1_4, data_4, valid_4;
    logic [3:0] grant_4;
    logic [1:0] chan_4;

    logic       mux_out_1, mux_out_2, mux_out_4;

    assign mux_out_1 = mux_in[{s0_1, s1_1}];
    assign mux_out_2 = mux_in[{s0_2, s1_2}];
    assign mux_out_4 = mux_in[{s0_4, s1_4}];

    // Observation vectors: {s0, s1, grant[3:0], data, chan[1:0], valid}
    logic [9:0] o1, o2, o4;
    assign o1 = {s0_1, s1_1, grant_1, data_1, chan_1, valid_1};
    assign o2 = {s0_2, s1_2, grant_2, data_2, chan_2, valid_2};
    assign o4 = {s0_4, s1_4, grant_4, data_4, chan_4, valid_4};

    int tests;
    int fails;

    mux4_scan_arbiter #(.SETTLE(1)) u1 (
        .clk(clk), .reset(reset), .req(req), .mux_out(mux_out_1), .ready(ready),
        .s0(s0_1), .s1(s1_1), .grant(grant_1), .data(data_1), .chan(chan_1), .valid(valid_1)
    );
    mux4_scan_arbiter #(.SETTLE(2)) u2 (
        .clk(clk), .reset(reset), .req(req), .mux_out(mux_out_2), .ready(ready),
        .s0(s0_2), .s1(s1_2), .grant(grant_2), .data(data_2), .chan(chan_2), .valid(valid_2)
    );
    mux4_scan_arbiter #(.SETTLE(4)) u4 (
        .clk(clk), .reset(reset), .req(req), .mux_out(mux_out_4), .ready(ready),
        .s0(s0_4), .s1(s1_4), .grant(grant_4), .data(data_4), .chan(chan_4), .valid(valid_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] mk(input logic [1:0] sel, input logic [3:0] g,
                                      input logic d, input logic [1:0] c, input logic v);
        return {sel, g, d, c, v};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'b0000;
        ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] exp;
        reset  = 1'b1;
        req    = 4'b0000;
        ready  = 1'b0;
        mux_in = 4'b0000;
        tick();
        tick();
        reset = 1'b0;
        exp = '0;
        tests++;
        if (o1 !== exp) begin fails++; $display("FAIL reset_u1 got=%b exp=%b", o1, exp); end
        tests++;
        if (o2 !== exp) begin fails++; $display("FAIL reset_u2 got=%b exp=%b", o2, exp); end
        tests++;
        if (o4 !== exp) begin fails++; $display("FAIL reset_u4 got=%b exp=%b", o4, exp); end
        ready = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            tests++;
            if ({o1, o4} !== {exp, exp}) begin
                fails++;
                $display("FAIL idle_hold t=%0d got=%b/%b exp=%b", t, o1, o4, exp);
            end
        end
    endtask

    task automatic test_single();
        logic [9:0] exp;
        do_reset();
        req    = 4'b0100;
        mux_in = 4'b0100;
        ready  = 1'b1;
        tick();
        exp = mk(2'b10, 4'b0100, 1'b0, 2'd0, 1'b0);
        tests++;
        if (o1 !== exp) begin fails++; $display("FAIL single_select got=%b exp=%b", o1, exp); end
        req = 4'b0000;
        tick();
        exp = mk(2'b10, 4'b0000, 1'b1, 2'd2, 1'b1);
        tests++;
        if (o1 !== exp) begin fails++; $display("FAIL single_sample got=%b exp=%b", o1, exp); end
        tick();
        exp = mk(2'b10, 4'b0000, 1'b1, 2'd2, 1'b0);
        tests++;
        if (o1 !== exp) begin fails++; $display("FAIL single_drop got=%b exp=%b", o1, exp); end
    endtask

    task automatic test_round_robin();
        logic [9:0] exp;
        int k, lastk;
        logic ld;
        do_reset();
        req    = 4'b1111;
        mux_in = 4'b1010;
        ready  = 1'b1;
        for (int t = 1; t <= 15; t++) begin
            tick();
            k     = ((t - 1) / 3) % 4;
            lastk = (t >= 3) ? ((t / 3) - 1) % 4 : 0;
            ld    = (t >= 3) ? mux_in[lastk] : 1'b0;
            exp = mk(2'(k), (t % 3 == 0) ? 4'b0000 : (4'b0001 << k), ld, 2'(lastk), (t % 3 == 0));
            tests++;
            if (o2 !== exp) begin
                fails++;
                $display("FAIL round_robin t=%0d got=%b exp=%b", t, o2, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp;
        do_reset();
        req    = 4'b0011;
        mux_in = 4'b0001;
        ready  = 1'b0;
        tick();
        exp = mk(2'b00, 4'b0001, 1'b0, 2'd0, 1'b0);
        tests++;
        if (o1 !== exp) begin fails++; $display("FAIL bp_select got=%b exp=%b", o1, exp); end
        for (int t = 2; t <= 7; t++) begin
            tick();
            exp = mk(2'b00, 4'b0000, 1'b1, 2'd0, 1'b1);
            tests++;
            if (o1 !== exp) begin
                fails++;
                $display("FAIL bp_frozen t=%0d got=%b exp=%b", t, o1, exp);
            end
        end
        ready = 1'b1;
        tick();
        exp = mk(2'b01, 4'b0010, 1'b1, 2'd0, 1'b0);
        tests++;
        if (o1 !== exp) begin fails++; $display("FAIL bp_regrant got=%b exp=%b", o1, exp); end
        tick();
        exp = mk(2'b01, 4'b0000, 1'b0, 2'd1, 1'b1);
        tests++;
        if (o1 !== exp) begin fails++; $display("FAIL bp_second got=%b exp=%b", o1, exp); end
    endtask

    task automatic test_pulse();
        logic [9:0] exp;
        do_reset();
        req    = 4'b1000;
        mux_in = 4'b1000;
        ready  = 1'b1;
        tick();
        req = 4'b0000;
        exp = mk(2'b11, 4'b1000, 1'b0, 2'd0, 1'b0);
        tests++;
        if (o4 !== exp) begin fails++; $display("FAIL pulse_t1 got=%b exp=%b", o4, exp); end
        for (int t = 2; t <= 4; t++) begin
            tick();
            tests++;
            if (o4 !== exp) begin fails++; $display("FAIL pulse_hold t=%0d got=%b exp=%b", t, o4, exp); end
        end
        tick();
        exp = mk(2'b11, 4'b0000, 1'b1, 2'd3, 1'b1);
        tests++;
        if (o4 !== exp) begin fails++; $display("FAIL pulse_sample got=%b exp=%b", o4, exp); end
        tick();
        exp = mk(2'b11, 4'b0000, 1'b1, 2'd3, 1'b0);
        tests++;
        if (o4 !== exp) begin fails++; $display("FAIL pulse_done got=%b exp=%b", o4, exp); end
    endtask

    task automatic test_reset_mid();
        logic [9:0] exp;
        do_reset();
        // Serve channel 0 once so the pointer moves to 1.
        req    = 4'b0001;
        mux_in = 4'b0001;
        ready  = 1'b1;
        tick();
        req = 4'b0000;
        repeat (5) tick();
        req   = 4'b0011;
        ready = 1'b0;
        tick();
        exp = mk(2'b01, 4'b0010, 1'b1, 2'd0, 1'b0);
        tests++;
        if (o4 !== exp) begin fails++; $display("FAIL mid_ptr got=%b exp=%b", o4, exp); end
        // Reset while in SEL.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++;
        if (o4 !== 10'd0) begin fails++; $display("FAIL mid_rst_sel got=%b exp=%b", o4, 10'd0); end
        tick();
        exp = mk(2'b00, 4'b0001, 1'b0, 2'd0, 1'b0);
        tests++;
        if (o4 !== exp) begin fails++; $display("FAIL mid_rearb got=%b exp=%b", o4, exp); end
        repeat (4) tick();
        exp = mk(2'b00, 4'b0000, 1'b1, 2'd0, 1'b1);
        tests++;
        if (o4 !== exp) begin fails++; $display("FAIL mid_hold got=%b exp=%b", o4, exp); end
        // Reset while in HOLD.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++;
        if (o4 !== 10'd0) begin fails++; $display("FAIL mid_rst_hold got=%b exp=%b", o4, 10'd0); end
        tick();
        exp = mk(2'b00, 4'b0001, 1'b0, 2'd0, 1'b0);
        tests++;
        if (o4 !== exp) begin fails++; $display("FAIL mid_after got=%b exp=%b", o4, exp); end
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        reset  = 1'b1;
        req    = 4'b0000;
        mux_in = 4'b0000;
        ready  = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_back_to_back();
        test_pulse();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
